// File: rtl/spi_flash_master.sv
// SPI flash master on the rcpu IO bus: a DATA write shifts one byte out and one byte in (mode 0, MSB first).
// Latency: a transfer takes 16*CLK_DIV cycles from the accepting edge; register reads are combinational.
// Backpressure: none; a DATA write or CS change while busy is dropped and latched into ovr.
module spi_flash_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned DATA_BIT = 9,
  parameter int unsigned STAT_BIT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:15] io_address,
  input  logic        io_write_enable,
  input  logic        io_read_enable,
  input  logic [0:15] io_write_data,
  output logic [0:15] io_read_data,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       cs_n_q, cs_n_d;
  logic       ovr_q, ovr_d;

  logic       busy;
  logic       wr_data;
  logic       wr_stat;

  // The read strobe and upper write byte carry no information for this peripheral.
  logic       unused_inputs;
  assign unused_inputs = ^{io_read_enable, io_write_data[0:7]};

  assign busy    = (state_q != ST_IDLE);
  assign wr_data = io_write_enable & io_address[DATA_BIT];
  assign wr_stat = io_write_enable & io_address[STAT_BIT];

  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

  // Register read mux; with both selects set the two registers are ORed.
  always_comb begin
    io_read_data = '0;
    if (io_address[DATA_BIT]) begin
      io_read_data[8:15] = rx_byte_q;
    end
    if (io_address[STAT_BIT]) begin
      io_read_data = io_read_data | {13'd0, ovr_q, busy, cs_n_q};
    end
  end

  // STATUS write is applied first, then the DATA start; the SCK sequencer runs after that.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bitcnt_d   = bitcnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    ovr_d      = ovr_q;

    if (wr_stat) begin
      if (io_write_data[14]) begin
        ovr_d = 1'b0;
      end
      if (!busy) begin
        cs_n_d = io_write_data[15];
      end else if (io_write_data[15] != cs_n_q) begin
        // Moving CS under a live transfer would corrupt the flash command.
        ovr_d = 1'b1;
      end
    end
    if (wr_data && busy) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_data) begin
          tx_shift_d = io_write_data[8:15];
          mosi_d     = io_write_data[8];
          div_d      = '0;
          bitcnt_d   = '0;
          state_d    = ST_LO;
        end
      end
      ST_LO: begin
        if (div_q == DIV_LAST) begin
          sck_d      = 1'b1;
          rx_shift_d = {rx_shift_q[6:0], spi_miso};
          div_d      = '0;
          state_d    = ST_HI;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_HI: begin
        if (div_q == DIV_LAST) begin
          sck_d = 1'b0;
          div_d = '0;
          if (bitcnt_q == 3'd7) begin
            rx_byte_d = rx_shift_q;
            state_d   = ST_IDLE;
          end else begin
            bitcnt_d   = bitcnt_q + 3'd1;
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            mosi_d     = tx_shift_q[6];
            state_d    = ST_LO;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any transfer on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bitcnt_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bitcnt_q   <= bitcnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      ovr_q      <= ovr_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_master.sv
// Directed-random bench for spi_flash_master with a byte-level flash model on MISO.
// Two instances share the IO bus: CLK_DIV=4 for most checks, CLK_DIV=1 for back-to-back timing.
// Every wait is bounded; expected values come from transfer-level rules, not from the RTL.
module tb_spi_flash_master;

  localparam int DIV0 = 4;
  localparam int DIV1 = 1;
  localparam logic [0:15] A_DATA = 16'h0040;  // io_address[9]
  localparam logic [0:15] A_STAT = 16'h0020;  // io_address[10]
  localparam logic [0:15] A_BOTH = 16'h0060;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:15] io_address;
  logic        io_write_enable;
  logic        io_read_enable;
  logic [0:15] io_write_data;
  logic [0:15] rd0, rd1;
  logic        sck0, mosi0, miso0, cs0;
  logic        sck1, mosi1, miso1, cs1;

  int          n_cmp = 0;
  int          n_err = 0;

  // Flash model state: rising SCK edges seen and the byte pattern to return.
  int          rc0 = 0;
  int          rc1 = 0;
  int          base0 = 0;
  int          base1 = 0;
  logic [7:0]  pat0 = 8'h00;
  logic [15:0] pat1 = 16'h0000;

  spi_flash_master #(.CLK_DIV(DIV0), .DATA_BIT(9), .STAT_BIT(10)) u_dut0 (
    .clk(clk), .reset(reset), .io_address(io_address), .io_write_enable(io_write_enable),
    .io_read_enable(io_read_enable), .io_write_data(io_write_data), .io_read_data(rd0),
    .spi_sck(sck0), .spi_mosi(mosi0), .spi_miso(miso0), .spi_cs_n(cs0)
  );

  spi_flash_master #(.CLK_DIV(DIV1), .DATA_BIT(9), .STAT_BIT(10)) u_dut1 (
    .clk(clk), .reset(reset), .io_address(io_address), .io_write_enable(io_write_enable),
    .io_read_enable(io_read_enable), .io_write_data(io_write_data), .io_read_data(rd1),
    .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso1), .spi_cs_n(cs1)
  );

  always #5 clk = ~clk;

  always @(posedge sck0) rc0 <= rc0 + 1;
  always @(posedge sck1) rc1 <= rc1 + 1;

  function automatic logic pick_bit(input logic [15:0] v, input int width, input int i);
    if (i < 0 || i >= width) return 1'b0;
    return v[width - 1 - i];
  endfunction

  // Flash presents the next pattern bit after each rising SCK, ahead of the following rise.
  always @(negedge clk) begin
    miso0 <= pick_bit({8'h00, pat0}, 8, rc0 - base0);
    miso1 <= pick_bit(pat1, 16, rc1 - base1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [0:15] a, input logic [0:15] d);
    @(negedge clk);
    io_address = a; io_write_data = d; io_write_enable = 1'b1;
    @(negedge clk);
    io_write_enable = 1'b0; io_address = '0; io_write_data = '0;
  endtask

  task automatic rd(input logic [0:15] a, output logic [0:15] d);
    @(negedge clk);
    io_address = a; io_read_enable = 1'b1;
    #1;
    d = rd0;
    io_read_enable = 1'b0;
  endtask

  // One byte transfer on instance 0, optionally with a disturbing write at cycle inj_cyc.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] pt, input int inj_kind,
                      input int inj_cyc, input logic [15:0] exp_stat);
    int          busy_cnt = 0;
    int          rises = 0;
    int          first_rise = 0;
    logic [7:0]  got = '0;
    logic        psck = 1'b0;
    logic        first_mosi = 1'b0;
    logic [0:15] mid_stat = '0;
    logic        cs_mid = 1'b1;
    logic        done = 1'b0;
    logic [0:15] d;
    pat0 = pt;
    base0 = rc0;
    @(negedge clk);
    io_address = A_DATA; io_write_data = {8'h00, tx}; io_write_enable = 1'b1;
    for (int k = 1; k <= 200 && !done; k++) begin
      @(negedge clk);
      io_write_enable = 1'b0; io_address = A_STAT; io_write_data = '0;
      #1;
      if (k == 1) first_mosi = mosi0;
      if (k == inj_cyc + 1) begin
        mid_stat = rd0;
        cs_mid = cs0;
      end
      if (sck0 && !psck) begin
        rises++;
        got = {got[6:0], mosi0};
        if (first_rise == 0) first_rise = k;
      end
      psck = sck0;
      if (rd0[14]) busy_cnt++;
      else done = 1'b1;
      if (k == inj_cyc) begin
        case (inj_kind)
          1: begin io_address = A_DATA; io_write_data = {8'h00, 8'($urandom)}; io_write_enable = 1'b1; end
          2: begin io_address = A_STAT; io_write_data = 16'h0001; io_write_enable = 1'b1; end
          3: begin io_address = A_BOTH; io_write_data = 16'h0002; io_write_enable = 1'b1; end
          default: ;
        endcase
      end
    end
    chk("busy_len", busy_cnt, 16 * DIV0);
    chk("mosi_first", first_mosi, tx[7]);
    chk("first_rise", first_rise, DIV0 + 1);
    chk("rise_cnt", rises, 8);
    chk("mosi_bits", got, tx);
    if (inj_kind != 0) chk("mid_status", mid_stat, 16'h0006);
    if (inj_kind == 2) chk("cs_hold", cs_mid, 1'b0);
    rd(A_STAT, d);
    chk("end_status", d, exp_stat);
    rd(A_DATA, d);
    chk("rx_byte", d, {8'h00, pt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [0:15] d;
    logic [7:0]  tx, pt, tx_a, tx_b;
    logic [15:0] got16;
    logic        ok, b, prev, psck;
    int          hold, rises, nw, first_low, second_high, second_low, high_cnt;

    reset = 1'b1; io_address = '0; io_write_enable = 1'b0;
    io_read_enable = 1'b0; io_write_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    rd(A_STAT, d);
    chk("rst_status", d, 16'h0001);
    chk("rst_status_div1", rd1, 16'h0001);
    rd(A_DATA, d);
    chk("rst_data", d, 16'h0000);
    chk("rst_sck", sck0, 1'b0);
    chk("rst_mosi", mosi0, 1'b0);

    // Directed 0x9F / 0xEF transfer, then random bytes
    wr(A_STAT, 16'h0000);
    rd(A_STAT, d);
    chk("cs_assert", d, 16'h0000);
    chk("cs_pin", cs0, 1'b0);
    xfer(8'h9F, 8'hEF, 0, 0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tx = 8'($urandom); pt = 8'($urandom);
      xfer(tx, pt, 0, 0, 16'h0000);
    end

    // DATA write while busy: overrun, transfer intact
    tx = 8'($urandom); pt = 8'($urandom);
    xfer(tx, pt, 1, 10, 16'h0004);
    wr(A_STAT, 16'h0002);
    rd(A_STAT, d);
    chk("ovr_clear", d, 16'h0000);

    // CS change while busy: ignored, overrun
    tx = 8'($urandom); pt = 8'($urandom);
    xfer(tx, pt, 2, 20, 16'h0004);
    chk("cs_after_xfer", cs0, 1'b0);
    wr(A_STAT, 16'h0002);

    // Both selects while busy: clear-ovr and overrun in one write, set wins
    tx = 8'($urandom); pt = 8'($urandom);
    xfer(tx, pt, 3, 30, 16'h0004);
    rd(A_BOTH, d);
    chk("both_read", d, {8'h00, pt} | 16'h0004);
    wr(A_STAT, 16'h0002);

    // Reset in the middle of a transfer
    tx = 8'($urandom); pt = 8'($urandom_range(1, 255));
    xfer(tx, pt, 0, 0, 16'h0000);
    pat0 = 8'($urandom);
    base0 = rc0;
    wr(A_DATA, {8'h00, 8'($urandom)});
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (rc0 - base0 >= 3) ok = 1'b1;
    end
    chk("rst_wait", ok, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; io_address = A_STAT;
    #1;
    chk("abort_sck", sck0, 1'b0);
    chk("abort_cs", cs0, 1'b1);
    chk("abort_status", rd0, 16'h0001);
    rd(A_DATA, d);
    chk("abort_rx", d, 16'h0000);
    hold = rc0;
    repeat (40) @(negedge clk);
    chk("abort_no_sck", rc0, hold);

    // CLK_DIV=1: back-to-back writes on the cycle busy falls
    wr(A_STAT, 16'h0000);
    pat1 = 16'($urandom);
    base1 = rc1;
    tx_a = 8'($urandom); tx_b = 8'($urandom);
    @(negedge clk);
    io_address = A_DATA; io_write_data = {8'h00, tx_a}; io_write_enable = 1'b1;
    nw = 1; prev = 1'b0; psck = 1'b0; got16 = '0; rises = 0;
    first_low = 0; second_high = 0; second_low = 0; high_cnt = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      io_write_enable = 1'b0; io_address = A_STAT; io_write_data = '0;
      #1;
      b = rd1[14];
      if (sck1 && !psck) begin
        rises++;
        got16 = {got16[14:0], mosi1};
      end
      psck = sck1;
      if (b) high_cnt++;
      if (!b && first_low == 0) first_low = k;
      else if (b && first_low != 0 && second_high == 0) second_high = k;
      else if (!b && second_high != 0 && second_low == 0) second_low = k;
      if (nw == 1 && prev && !b) begin
        io_address = A_DATA; io_write_data = {8'h00, tx_b}; io_write_enable = 1'b1;
        nw = 2;
      end
      prev = b;
    end
    chk("b2b_first_end", first_low, 16 * DIV1 + 1);
    chk("b2b_second_start", second_high, 16 * DIV1 + 2);
    chk("b2b_second_end", second_low, 32 * DIV1 + 2);
    chk("b2b_busy_total", high_cnt, 32 * DIV1);
    chk("b2b_rises", rises, 16);
    chk("b2b_mosi", got16, {tx_a, tx_b});
    @(negedge clk);
    io_address = A_DATA;
    #1;
    chk("b2b_rx", rd1, {8'h00, pat1[7:0]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
